// File: rtl/cpu_types_pkg.sv
// Shared types for the N-way data cache: FSM states, field-width helpers
// and the cache line record.
package cpu_types_pkg;
  localparam int MAX_WORDS = 8;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT_HIT, CNT_MISS, DONE} dcache_state_t;

  // Width of an address field selecting one of n items (0 when n == 1).
  function automatic int fld_w(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Same, but at least 1 so it can size a real signal.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag is kept full width (address >> tag shift); unused data words prune away.
  typedef struct packed {
    logic                            valid;
    logic                            dirty;
    logic [31:0]                     tag;
    logic [MAX_WORDS-1:0][31:0]      data;
  } dline_t;
endpackage

// File: rtl/dcache_lru.sv
// True-LRU age tracking per set; age 0 is most recent, age WAYS-1 is the victim.
module dcache_lru
  import cpu_types_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  localparam int WW = sel_w(WAYS),
  localparam int SW = sel_w(SETS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     access,
  input  logic [SW-1:0]            idx,
  input  logic [WW-1:0]            way,
  output logic [SETS-1:0][WW-1:0]  victim
);
  logic [SETS-1:0][WAYS-1:0][WW-1:0] age;
  logic [WW-1:0] old_age;

  assign old_age = age[idx][way];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WW'(w);
    end else if (access) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == way)            age[idx][w] <= '0;
        else if (age[idx][w] < old_age) age[idx][w] <= age[idx][w] + WW'(1);
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (age[s][w] == WW'(WAYS-1)) victim[s] = WW'(w);
  end
endmodule

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way set-associative data cache with
// hit/miss counters dumped to memory after the halt flush.
module dcache_nway
  import cpu_types_pkg::*;
#(
  parameter int          WAYS     = 2,
  parameter int          SETS     = 8,
  parameter int          WORDS    = 2,
  parameter logic [31:0] HIT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  localparam int WW  = sel_w(WAYS);
  localparam int SW  = sel_w(SETS);
  localparam int BW  = fld_w(WORDS);
  localparam int WL  = fld_w(WAYS);
  localparam int TSH = 2 + BW + fld_w(SETS);

  dcache_state_t state;
  dline_t [WAYS-1:0][SETS-1:0] lines;

  logic [SW-1:0] idx, fset;
  logic [WW-1:0] hway, vway, vic, inv, fway;
  logic [2:0]    blk, wcnt;
  logic [31:0]   tag, hits, misses;
  logic [9:0]    fpos;
  logic          hit, has_inv, req, replay, last_word, last_entry, fdirty;
  logic [SETS-1:0][WW-1:0] lru_vic;

  function automatic logic [31:0] mkaddr(input logic [31:0] t, input logic [SW-1:0] s,
                                         input logic [2:0] w);
    return (t << TSH) | (32'(s) << (2 + BW)) | (32'(w) << 2);
  endfunction

  assign idx        = SW'((dmemaddr >> (2 + BW)) & (SETS - 1));
  assign blk        = 3'((dmemaddr >> 2) & (WORDS - 1));
  assign tag        = dmemaddr >> TSH;
  assign req        = dmemREN | dmemWEN;
  assign fset       = SW'(fpos >> WL);
  assign fway       = WW'(fpos & 10'(WAYS - 1));
  assign last_word  = wcnt == 3'(WORDS - 1);
  assign last_entry = fpos == 10'(WAYS * SETS - 1);
  assign fdirty     = lines[fway][fset].valid && lines[fway][fset].dirty;

  // Lookup and victim choice: lowest invalid way wins over LRU.
  always_comb begin
    hit = 1'b0; hway = '0; has_inv = 1'b0; inv = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (lines[w][idx].valid && lines[w][idx].tag == tag) begin hit = 1'b1; hway = WW'(w); end
      if (!lines[w][idx].valid) begin has_inv = 1'b1; inv = WW'(w); end
    end
    vic = has_inv ? inv : lru_vic[idx];
  end

  dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk(CLK), .rst(RST), .access(dhit), .idx(idx), .way(hway), .victim(lru_vic)
  );

  always_comb begin
    dhit = 1'b0; dmemload = '0; flushed = 1'b0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    case (state)
      IDLE: if (!halt && req && hit) begin
        dhit = 1'b1; dmemload = lines[hway][idx].data[blk];
      end
      WB: begin
        dWEN = 1'b1; daddr = mkaddr(lines[vway][idx].tag, idx, wcnt);
        dstore = lines[vway][idx].data[wcnt];
      end
      FILL: begin dREN = 1'b1; daddr = mkaddr(tag, idx, wcnt); end
      FLUSH: if (fdirty) begin
        dWEN = 1'b1; daddr = mkaddr(lines[fway][fset].tag, fset, wcnt);
        dstore = lines[fway][fset].data[wcnt];
      end
      CNT_HIT:  begin dWEN = 1'b1; daddr = HIT_ADDR;         dstore = hits;   end
      CNT_MISS: begin dWEN = 1'b1; daddr = HIT_ADDR + 32'd4; dstore = misses; end
      DONE:     flushed = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE; wcnt <= '0; vway <= '0; fpos <= '0;
      hits <= '0; misses <= '0; replay <= 1'b0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) begin
          lines[w][s].valid <= 1'b0;
          lines[w][s].dirty <= 1'b0;
        end
    end else begin
      case (state)
        IDLE: begin
          replay <= 1'b0;
          if (halt) begin
            state <= FLUSH; fpos <= '0; wcnt <= '0;
          end else if (req && hit) begin
            // The replay after a fill is the tail of a miss, not a new hit.
            if (!replay) hits <= hits + 32'd1;
            if (dmemWEN) begin
              lines[hway][idx].data[blk] <= dmemstore;
              lines[hway][idx].dirty     <= 1'b1;
            end
          end else if (req) begin
            misses <= misses + 32'd1; vway <= vic; wcnt <= '0;
            state  <= (lines[vic][idx].valid && lines[vic][idx].dirty) ? WB : FILL;
          end
        end
        WB: if (!dwait) begin
          wcnt <= last_word ? 3'd0 : wcnt + 3'd1;
          if (last_word) state <= FILL;
        end
        FILL: if (!dwait) begin
          lines[vway][idx].data[wcnt] <= dload;
          if (last_word) begin
            wcnt <= '0; replay <= 1'b1; state <= IDLE;
            lines[vway][idx].valid <= 1'b1;
            lines[vway][idx].dirty <= 1'b0;
            lines[vway][idx].tag   <= tag;
          end else wcnt <= wcnt + 3'd1;
        end
        FLUSH: if (!fdirty || (!dwait && last_word)) begin
          wcnt <= '0;
          if (fdirty) lines[fway][fset].dirty <= 1'b0;
          if (last_entry) state <= CNT_HIT;
          else fpos <= fpos + 10'd1;
        end else if (!dwait) wcnt <= wcnt + 3'd1;
        CNT_HIT:  if (!dwait) state <= CNT_MISS;
        CNT_MISS: if (!dwait) state <= DONE;
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Randomized bench for dcache_nway against a recency-list cache model and
// an address-indexed backing memory.
module tb_dcache_nway;
  localparam int WAYS = 4, SETS = 8, WORDS = 4;
  localparam logic [31:0] HIT_ADDR = 32'h3100;

  logic CLK = 1'b0, RST, halt, dmemREN, dmemWEN, dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

  always #5 CLK = ~CLK;

  dcache_nway #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .HIT_ADDR(HIT_ADDR)) dut (
    .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: each set holds up to WAYS lines placed in slots; eviction picks the
  // least recently touched line by timestamp.
  typedef struct {
    bit                      valid;
    bit                      dirty;
    int unsigned             tag;
    longint                  stamp;
    logic [WORDS-1:0][31:0]  data;
  } mline_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } xfer_t;

  mline_t      m [SETS][WAYS];
  longint      now;
  int unsigned m_hits, m_misses;
  logic [31:0] mem [int unsigned];
  xfer_t       xq [$];
  bit          stall;
  int          stall_cnt;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E3779B1 ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] laddr(input int unsigned t, input int s, input int k);
    return 32'(((t * SETS + s) * WORDS + k) * 4);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m[s][w].valid = 0; m[s][w].dirty = 0; m[s][w].stamp = 0;
      end
    now = 0; m_hits = 0; m_misses = 0; xq.delete();
  endfunction

  // Returns expected request-to-dhit latency with a zero-wait memory.
  function automatic int model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                      output logic [31:0] ld);
    int unsigned wi = a >> 2;
    int blk = int'(wi % WORDS), s = int'((wi / WORDS) % SETS);
    int unsigned t = wi / (WORDS * SETS);
    int way = -1, lat = 0;
    now++;
    for (int w = 0; w < WAYS; w++) if (m[s][w].valid && m[s][w].tag == t) way = w;
    if (way >= 0) m_hits++;
    else begin
      m_misses++;
      for (int w = 0; w < WAYS; w++) if (!m[s][w].valid && way < 0) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < WAYS; w++) if (m[s][w].stamp < m[s][way].stamp) way = w;
      end
      lat = WORDS + 1;
      if (m[s][way].valid && m[s][way].dirty) begin
        lat += WORDS;
        for (int k = 0; k < WORDS; k++)
          xq.push_back('{1'b1, laddr(m[s][way].tag, s, k), m[s][way].data[k]});
      end
      for (int k = 0; k < WORDS; k++) begin
        xq.push_back('{1'b0, laddr(t, s, k), 32'h0});
        m[s][way].data[k] = mrd(laddr(t, s, k));
      end
      m[s][way].valid = 1; m[s][way].dirty = 0; m[s][way].tag = t;
    end
    m[s][way].stamp = now;
    if (wr) begin m[s][way].data[blk] = d; m[s][way].dirty = 1; end
    ld = m[s][way].data[blk];
    return lat;
  endfunction

  // Memory side of one cycle: checks the DUT's bus against the expected transfer.
  task automatic bus_step();
    xfer_t x;
    check("one_dir", 32'(dREN & dWEN), 0);
    if (dREN || dWEN) begin
      check("xfer_expected", 32'(xq.size() != 0), 1);
      if (xq.size() != 0) begin
        x = xq[0];
        check("xfer_dir", 32'(dWEN), 32'(x.wr));
        check("xfer_addr", daddr, x.addr);
        if (x.wr) check("xfer_data", dstore, x.data);
        if (stall) begin
          dwait = (stall_cnt < 3);
          stall_cnt = dwait ? stall_cnt + 1 : 0;
        end else dwait = 0;
        dload = x.wr ? 32'h0 : mrd(x.addr);
        if (!dwait) begin
          if (x.wr) mem[x.addr] = x.data;
          void'(xq.pop_front());
        end
      end
    end else begin
      check("bus_idle", daddr | dstore, 0);
      dwait = 0;
    end
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, output int lat);
    int elat, cyc;
    logic [31:0] eld;
    bit done;
    elat = model_access(wr, a, d, eld);
    dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d;
    done = 0; cyc = 0; lat = -1;
    while (!done && cyc < 400) begin
      #1;
      if (dhit) begin
        check("pending_at_dhit", xq.size(), 0);
        if (!stall) check("latency", cyc, elat);
        if (!wr) check("load_data", dmemload, eld);
        done = 1; lat = cyc;
      end else bus_step();
      @(negedge CLK);
      cyc++;
    end
    check("dhit_seen", 32'(done), 1);
    if (!done) xq.delete();
    dmemREN = 0; dmemWEN = 0;
  endtask

  task automatic do_halt();
    bit done = 0;
    int cyc = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m[s][w].valid && m[s][w].dirty) begin
          for (int k = 0; k < WORDS; k++)
            xq.push_back('{1'b1, laddr(m[s][w].tag, s, k), m[s][w].data[k]});
          m[s][w].dirty = 0;
        end
    xq.push_back('{1'b1, HIT_ADDR, m_hits});
    xq.push_back('{1'b1, HIT_ADDR + 32'd4, m_misses});
    halt = 1;
    while (!done && cyc < 2000) begin
      #1;
      if (flushed) done = 1;
      else begin check("flush_no_dhit", 32'(dhit), 0); bus_step(); end
      @(negedge CLK);
      cyc++;
    end
    check("flushed_seen", 32'(done), 1);
    check("flush_pending", xq.size(), 0);
    dmemREN = 1; dmemaddr = 32'h100; halt = 0;
    repeat (5) begin
      #1;
      check("flushed_hold", 32'(flushed), 1);
      check("done_no_dhit", 32'(dhit), 0);
      @(negedge CLK);
    end
    dmemREN = 0;
  endtask

  task automatic do_reset();
    RST = 1; halt = 0; dmemREN = 0; dmemWEN = 0;
    repeat (2) @(negedge CLK);
    RST = 0;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    halt = 0; dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0;
    dwait = 0; dload = 0; stall = 0; stall_cnt = 0;
    do_reset();
    #1;
    check("rst_ctl", {28'h0, dhit, flushed, dREN, dWEN}, 0);
    check("rst_daddr", daddr, 0);
    check("rst_dstore", dstore, 0);
    check("rst_dmemload", dmemload, 0);
    @(negedge CLK);

    // Reset in the middle of a fill must drop the partial line.
    dmemREN = 1; dmemaddr = 32'h200;
    @(negedge CLK); #1;
    check("mf_dren", 32'(dREN), 1);
    check("mf_addr0", daddr, 32'h200);
    dload = mrd(32'h200); dwait = 0;
    @(negedge CLK); #1;
    check("mf_addr1", daddr, 32'h204);
    RST = 1; dmemREN = 0;
    @(negedge CLK);
    RST = 0; model_reset();
    #1;
    check("mf_rst_ctl", {28'h0, dhit, flushed, dREN, dWEN}, 0);
    check("mf_rst_daddr", daddr, 0);
    @(negedge CLK);
    access(0, 32'h200, 0, lat);
    check("mf_refill_miss", lat, WORDS + 1);

    // Cold miss then hit.
    access(0, 32'h40, 0, lat);
    check("cold_miss_lat", lat, WORDS + 1);
    access(0, 32'h40, 0, lat);
    check("warm_hit_lat", lat, 0);

    // Five tags into set 0, then LRU behaviour.
    for (int t = 1; t <= 5; t++) access(0, 32'(t * SETS * WORDS * 4), 0, lat);
    access(0, 32'(2 * SETS * WORDS * 4), 0, lat);
    check("lru_t2_hit", lat, 0);
    access(0, 32'(1 * SETS * WORDS * 4), 0, lat);
    check("lru_t1_miss", lat, WORDS + 1);

    // Dirty line 0x80 pushed out by conflict misses.
    access(1, 32'h80, 32'hDEADBEEF, lat);
    for (int t = 6; t <= 9; t++) access(0, 32'(t * SETS * WORDS * 4), 0, lat);
    check("wb_mem_0x80", mrd(32'h80), 32'hDEADBEEF);

    // Stalled memory.
    stall = 1;
    for (int i = 0; i < 30; i++)
      access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)) << 2, $urandom, lat);
    stall = 0;

    // Zero-wait random traffic.
    for (int i = 0; i < 200; i++)
      access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)) << 2, $urandom, lat);

    // Two dirty lines, three hits, two misses, then halt.
    do_reset();
    @(negedge CLK);
    access(1, 32'h100, $urandom, lat);
    access(1, 32'h114, $urandom, lat);
    access(0, 32'h100, 0, lat);
    access(0, 32'h114, 0, lat);
    access(0, 32'h104, 0, lat);
    do_halt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised write-back, write-allocate, N-way set-associative data cache between the datapath and the cache/memory controller.
- Generalises the 2-way/8-set/2-word data cache to configurable ways, sets and block size.
- Uses true LRU replacement and counts both hits and misses.
- On halt it flushes all dirty blocks, writes the hit count, then the miss count, to memory, and asserts flushed.

Parameters:
WAYS, 2, associativity; power of 2, 1..8
SETS, 8, sets per way; power of 2, 2..64
WORDS, 2, 32-bit words per block; power of 2, 1..8
HIT_ADDR, 32'h3100, hit-count write address; miss count goes to HIT_ADDR+4

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock; reset is synchronous and active-high
halt  in  1  datapath halt request
dmemREN  in  1  datapath load request
dmemWEN  in  1  datapath store request (never together with dmemREN)
dmemaddr  in  32  word-aligned byte address
dmemstore  in  32  store data
dhit  out  1  request complete this cycle
dmemload  out  32  load data, valid when dhit
flushed  out  1  flush and counter write complete; sticky
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory address
dstore  out  32  memory write data
dwait  in  1  memory busy; a transfer completes in any cycle it is 0
dload  in  32  memory read data

Behaviour:
- Address split: bytoff [1:0]; blkoff next log2(WORDS) bits; idx next log2(SETS) bits; tag is the remainder.
- Line state: valid, dirty, tag, WORDS data words.
- Per-set LRU age: log2(WAYS) bits per way. Reset ages are way index (way 0 youngest).
- Reset:
  - all valid, dirty, counters, FSM and flushed clear next edge;
  - every output is 0 in IDLE with no request;
  - reset mid-transfer abandons it, with no partial line retained.
- Hit/miss counters: 32-bit, wrap at 2^32.
- States: IDLE, WB, FILL, FLUSH, CNT_HIT, CNT_MISS, DONE.
- IDLE:
  - halt=1 goes to FLUSH and has priority over any request.
  - Hit (valid and tag match in some way):
    - dhit=1 combinationally in the same cycle;
    - load returns the word;
    - store writes the word and sets dirty;
    - accessed way gets age 0; ways younger than its old age increment.
    - hit counter +1, unless the hit is the replay of a just-filled miss (replay flag).
  - Miss: victim is the invalid way with the lowest index, else the way with age WAYS-1.
    - Miss counter +1 once.
    - Go to WB if the victim is valid and dirty, else go to FILL.
- WB:
  - dWEN=1; daddr={victim tag, idx, word counter, 2'b00}; dstore=victim word; word counter starts at 0.
  - Word counter advances on dwait=0. After word WORDS-1 completes, go to FILL.
- FILL:
  - dREN=1; daddr={req tag, idx, word counter, 2'b00}.
  - On dwait=0 the word is written into the victim way.
  - After the last word: line valid=1, dirty=0, tag written; set replay flag; go to IDLE.
  - The request then hits one cycle later; dhit is never asserted in FILL.
  - Miss latency with no wait states is WORDS+1 cycles clean, 2*WORDS+1 cycles dirty.
- FLUSH:
  - Scans set 0..SETS-1, way 0..WAYS-1 within each set.
  - Clean or invalid entry: skipped in 1 cycle.
  - Dirty entry: writes WORDS words as in WB, then clears dirty.
  - After the last entry, go to CNT_HIT.
- CNT_HIT: dWEN=1, daddr=HIT_ADDR, dstore=hit count; on dwait=0 go to CNT_MISS.
- CNT_MISS: dWEN=1, daddr=HIT_ADDR+4, dstore=miss count; on dwait=0 go to DONE.
- DONE: flushed=1, held until RST; requests are ignored and dhit=0.
- dREN and dWEN are never both 1. daddr and dstore are 0 when both are 0.
- dwait held high stalls any memory state indefinitely with outputs stable.
- Request inputs must stay stable from miss until dhit.

Decomposition:
- In cpu_types_pkg: dcache_state_t enum; a parametrised address-field width function; the line record type (valid, dirty, tag, data array).
- Sub-module dcache_lru: per-set age array.
  - Inputs: access strobe, set, way.
  - Outputs: victim way per set.
  - Contains the age update and the victim select.

Test Plan:
- Default params; load 0x0000_0040 cold → 1 miss, FILL reads 0x40, 0x44; dhit on the third cycle with zero-wait memory; repeat load → dhit same cycle, hit count 1.
- WAYS=4, SETS=8, WORDS=4; loads to 5 tags mapping to set 0 (tags 1..5), then reload tag 1 → tag 1 evicted by tag 5; reload is a miss; tag 2 still hits.
- Store 0xDEADBEEF to 0x80, then conflict misses until line 0x80 is evicted → WB writes 0x80..0x80+4*WORDS-4 with 0xDEADBEEF at 0x80, before FILL reads.
- dwait=1 for 3 cycles per transfer during WB/FILL → outputs stable, no dhit, counters unchanged until completion.
- Two dirty lines, 3 hits, 2 misses, then halt → only the dirty lines are written; then 3 written to 0x3100 and 2 to 0x3104; flushed=1 stays high.
- RST asserted mid-FILL → next cycle all outputs 0 and the cache is empty; the next access to the same address misses.
